system_0_sysid_ext: RTL and testbench

Parametrised successor to the Qsys system ID peripheral: an Avalon-MM slave that holds a build ID, timestamp and capability word. It adds a free-running 64-bit uptime counter with coherent snapshot reads, a seconds counter, a control register and a bank of writable scratch registers. It sits on the system interconnect beside the processor and gives software a single place to identify the build and measure time since reset.

---
 rtl/sysid_ext_pkg.sv | 39 +++
 rtl/sysid_uptime_counter.sv | 66 ++++++
 rtl/system_0_sysid_ext.sv | 144 ++++++++++++++
 tb/tb_system_0_sysid_ext.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_ext_pkg.sv
// sysid_ext_pkg
// Shared definitions for the extended system ID peripheral:
//   - word offsets of every register in the Avalon-MM map
//   - the CAPS version byte
//   - CONTROL bit positions
//   - a byte-lane merge helper for partial writes
package sysid_ext_pkg;

  localparam int unsigned OFF_ID        = 0;
  localparam int unsigned OFF_TIMESTAMP = 1;
  localparam int unsigned OFF_CAPS      = 2;
  localparam int unsigned OFF_UPTIME_LO = 3;
  localparam int unsigned OFF_UPTIME_HI = 4;
  localparam int unsigned OFF_SECONDS   = 5;
  localparam int unsigned OFF_CONTROL   = 6;
  localparam int unsigned OFF_SCRATCH0  = 8;

  localparam logic [7:0] VERSION = 8'h02;

  localparam int unsigned CTRL_CLEAR_BIT  = 0;
  localparam int unsigned CTRL_FREEZE_BIT = 1;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] apply_byteenable(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  be
  );
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        result[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter
// Free-running 64-bit uptime counter plus a prescaled 32-bit seconds counter.
// Ports:
//   i_clk      system clock (rising edge)
//   i_rst_n    asynchronous active-low reset
//   i_clear    zero uptime, prescaler and seconds at this edge (wins over freeze)
//   i_freeze   hold all counters at their current values
//   o_uptime   64-bit cycle count since reset/clear, wraps
//   o_seconds  number of completed CLK_FREQ_HZ-cycle periods, wraps
module sysid_uptime_counter #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_freeze,
  output logic [63:0] o_uptime,
  output logic [31:0] o_seconds
);

  localparam int unsigned PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [63:0]        r_uptime;
  logic [PRESC_W-1:0] r_presc;
  logic [31:0]        r_seconds;

  logic [63:0]        w_uptime_next;
  logic [PRESC_W-1:0] w_presc_next;
  logic [31:0]        w_seconds_next;

  always_comb begin
    w_uptime_next  = r_uptime;
    w_presc_next   = r_presc;
    w_seconds_next = r_seconds;
    if (i_clear) begin
      w_uptime_next  = '0;
      w_presc_next   = '0;
      w_seconds_next = '0;
    end else if (!i_freeze) begin
      w_uptime_next = r_uptime + 64'd1;
      if (r_presc == PRESC_TC) begin
        w_presc_next   = '0;
        w_seconds_next = r_seconds + 32'd1;
      end else begin
        w_presc_next = r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_uptime  <= '0;
      r_presc   <= '0;
      r_seconds <= '0;
    end else begin
      r_uptime  <= w_uptime_next;
      r_presc   <= w_presc_next;
      r_seconds <= w_seconds_next;
    end
  end

  assign o_uptime  = r_uptime;
  assign o_seconds = r_seconds;

endmodule

// File: rtl/system_0_sysid_ext.sv
// system_0_sysid_ext
// Avalon-MM slave exposing build identification, a coherent 64-bit uptime,
// a seconds counter, a CONTROL register (CLEAR / FREEZE) and scratch words.
// Ports:
//   i_clock           system clock (rising edge)
//   i_reset_n         asynchronous active-low reset
//   i_address         word address
//   i_read            read strobe (fixed latency 1, no waitrequest)
//   i_write           write strobe
//   i_writedata       write data
//   i_byteenable      byte lanes for writes
//   o_readdata        registered read data, holds between reads
//   o_readdatavalid   one-cycle pulse the cycle after each read
module system_0_sysid_ext
  import sysid_ext_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'h63A2_D84C,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [31:0]       i_writedata,
  input  logic [3:0]        i_byteenable,
  output logic [31:0]       o_readdata,
  output logic              o_readdatavalid
);

  if (int'(NUM_SCRATCH) > (1 << ADDR_W) - 8) begin : g_bad_num_scratch
    $error("NUM_SCRATCH does not fit in the address map");
  end
  if (CLK_FREQ_HZ < 2) begin : g_bad_clk_freq
    $error("CLK_FREQ_HZ must be at least 2");
  end

  localparam int unsigned SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
  localparam logic [31:0] CAPS_WORD = {VERSION, 8'h00, 8'(ADDR_W), 8'(NUM_SCRATCH)};

  logic [31:0]            w_addr_ext;
  logic                   w_ctrl_wr;
  logic                   w_clear;
  logic [63:0]            w_uptime;
  logic [31:0]            w_seconds;
  logic [31:0]            w_rdata;
  logic [31:0]            w_scr_rdata;
  logic [SCR_N:0][31:0]   w_scr_acc;

  logic [SCR_N-1:0][31:0] r_scratch;
  logic [31:0]            r_snap_hi;
  logic                   r_freeze;
  logic [31:0]            r_readdata;
  logic                   r_readdatavalid;

  assign w_addr_ext = 32'(i_address);

  // CONTROL lives entirely in byte lane 0, so lane 0 gates both bits.
  assign w_ctrl_wr = i_write && i_byteenable[0] && (w_addr_ext == 32'(OFF_CONTROL));
  assign w_clear   = w_ctrl_wr && i_writedata[CTRL_CLEAR_BIT];

  sysid_uptime_counter #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_counter (
    .i_clk     (i_clock),
    .i_rst_n   (i_reset_n),
    .i_clear   (w_clear),
    .i_freeze  (r_freeze),
    .o_uptime  (w_uptime),
    .o_seconds (w_seconds)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_freeze <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_freeze <= i_writedata[CTRL_FREEZE_BIT];
    end
  end

  // A LO read latches the high word from the same pre-edge sample, so a
  // following HI read returns a value coherent with the LO just returned.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_snap_hi <= '0;
    end else if (i_read && (w_addr_ext == 32'(OFF_UPTIME_LO))) begin
      r_snap_hi <= w_uptime[63:32];
    end
  end

  // Scratch words; the read side is an AND-OR chain so no variable index
  // into the array is needed.
  assign w_scr_acc[0] = '0;
  for (genvar gi = 0; gi < int'(NUM_SCRATCH); gi++) begin : g_scratch
    logic w_hit;
    assign w_hit = (w_addr_ext == 32'(OFF_SCRATCH0 + gi));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_scratch[gi] <= '0;
      end else if (i_write && w_hit) begin
        r_scratch[gi] <= apply_byteenable(r_scratch[gi], i_writedata, i_byteenable);
      end
    end

    assign w_scr_acc[gi+1] = w_scr_acc[gi] | (w_hit ? r_scratch[gi] : 32'h0);
  end
  assign w_scr_rdata = w_scr_acc[NUM_SCRATCH];

  // Read mux works on register state before this edge, so a simultaneous
  // write is not visible to the read in the same cycle.
  always_comb begin
    w_rdata = '0;
    case (w_addr_ext)
      32'(OFF_ID):        w_rdata = ID_VALUE;
      32'(OFF_TIMESTAMP): w_rdata = TIMESTAMP;
      32'(OFF_CAPS):      w_rdata = CAPS_WORD;
      32'(OFF_UPTIME_LO): w_rdata = w_uptime[31:0];
      32'(OFF_UPTIME_HI): w_rdata = r_snap_hi;
      32'(OFF_SECONDS):   w_rdata = w_seconds;
      32'(OFF_CONTROL):   w_rdata = {30'b0, r_freeze, 1'b0};
      default:            w_rdata = w_scr_rdata;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= i_read;
      if (i_read) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign o_readdata      = r_readdata;
  assign o_readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_system_0_sysid_ext.sv
// Directed bench for system_0_sysid_ext, built with CLK_FREQ_HZ = 4 so that
// seconds ticks are visible within a few cycles. Inputs change on the falling
// edge; outputs are sampled on the falling edge after the capturing rise.
module tb_system_0_sysid_ext;

  logic        clk;
  logic        rst_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int tests = 0;
  int fails = 0;

  system_0_sysid_ext #(
    .ID_VALUE    (32'h63A2_D84C),
    .TIMESTAMP   (32'h0),
    .ADDR_W      (4),
    .NUM_SCRATCH (4),
    .CLK_FREQ_HZ (4)
  ) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_address       (address),
    .i_read          (read),
    .i_write         (write),
    .i_writedata     (writedata),
    .i_byteenable    (byteenable),
    .o_readdata      (readdata),
    .o_readdatavalid (readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Each bus task starts and ends on a falling edge and spans one rising edge.
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    address = a;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
    v = readdatavalid;
    $display("[TB] read  addr=%0d data=%h valid=%b", a, d, v);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a;
    writedata = d;
    byteenable = be;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    $display("[TB] write addr=%0d data=%h be=%b", a, d, be);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read = 1'b0;
    write = 1'b0;
    address = '0;
    writedata = '0;
    byteenable = '0;
    repeat (3) @(negedge clk);
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
    tests++; if (readdatavalid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected %b", readdatavalid, 1'b0); end
    rst_n = 1'b1;
  endtask

  // Starts right after reset release: rising edge k leaves uptime = k and
  // seconds = k/4 (integer division).
  task automatic test_seconds();
    logic [31:0] d;
    logic v;
    repeat (12) @(negedge clk);
    bus_read(4'd5, d, v);   // captured at edge 13: value after 12 edges
    tests++; if (d !== 32'd3) begin fails++; $display("FAIL seconds_12: got %h expected %h", d, 32'd3); end
    tests++; if (v !== 1'b1) begin fails++; $display("FAIL seconds_valid: got %b expected %b", v, 1'b1); end
    bus_read(4'd3, d, v);   // edge 14: uptime 13
    tests++; if (d !== 32'd13) begin fails++; $display("FAIL uptime_13: got %h expected %h", d, 32'd13); end
    bus_write(4'd6, 32'h2, 4'h1);  // edge 15 still counts, then frozen at 15
    bus_read(4'd3, d, v);
    tests++; if (d !== 32'd15) begin fails++; $display("FAIL uptime_frozen: got %h expected %h", d, 32'd15); end
    repeat (20) @(negedge clk);
    bus_read(4'd5, d, v);
    tests++; if (d !== 32'd3) begin fails++; $display("FAIL seconds_frozen: got %h expected %h", d, 32'd3); end
    bus_read(4'd3, d, v);
    tests++; if (d !== 32'd15) begin fails++; $display("FAIL uptime_frozen_20: got %h expected %h", d, 32'd15); end
    bus_read(4'd6, d, v);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL control_freeze_rb: got %h expected %h", d, 32'h2); end
  endtask

  task automatic test_ident();
    logic [31:0] d;
    logic v;
    bus_read(4'd0, d, v);
    tests++; if (d !== 32'h63A2_D84C) begin fails++; $display("FAIL id: got %h expected %h", d, 32'h63A2_D84C); end
    tests++; if (v !== 1'b1) begin fails++; $display("FAIL id_valid: got %b expected %b", v, 1'b1); end
    @(negedge clk);
    tests++; if (readdatavalid !== 1'b0) begin fails++; $display("FAIL valid_drop: got %b expected %b", readdatavalid, 1'b0); end
    tests++; if (readdata !== 32'h63A2_D84C) begin fails++; $display("FAIL readdata_hold: got %h expected %h", readdata, 32'h63A2_D84C); end
    // back-to-back reads
    bus_read(4'd1, d, v);
    tests++; if (d !== 32'h0 || v !== 1'b1) begin fails++; $display("FAIL timestamp: got %h/%b expected %h/1", d, v, 32'h0); end
    bus_read(4'd2, d, v);
    tests++; if (d !== 32'h0200_0404 || v !== 1'b1) begin fails++; $display("FAIL caps: got %h/%b expected %h/1", d, v, 32'h0200_0404); end
    bus_read(4'd7, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reserved7: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic v;
    bus_read(4'd8, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL scratch0_reset: got %h expected %h", d, 32'h0); end
    bus_write(4'd8, 32'hDEAD_BEEF, 4'b0101);
    bus_read(4'd8, d, v);
    tests++; if (d !== 32'h00AD_00EF) begin fails++; $display("FAIL scratch0_be: got %h expected %h", d, 32'h00AD_00EF); end
    bus_write(4'd9, 32'h1234_5678, 4'hF);
    bus_read(4'd9, d, v);
    tests++; if (d !== 32'h1234_5678) begin fails++; $display("FAIL scratch1: got %h expected %h", d, 32'h1234_5678); end
    bus_write(4'd11, 32'hA5A5_5A5A, 4'b1000);
    bus_read(4'd11, d, v);
    tests++; if (d !== 32'hA500_0000) begin fails++; $display("FAIL scratch3_be: got %h expected %h", d, 32'hA500_0000); end
    bus_read(4'd15, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL off15_read: got %h expected %h", d, 32'h0); end
    bus_write(4'd15, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'd15, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL off15_write: got %h expected %h", d, 32'h0); end
    bus_read(4'd8, d, v);
    tests++; if (d !== 32'h00AD_00EF) begin fails++; $display("FAIL scratch0_keep: got %h expected %h", d, 32'h00AD_00EF); end
  endtask

  // Counters are frozen on entry; preload uptime just below a high-word carry.
  task automatic test_snapshot();
    logic [31:0] d;
    logic v;
    force dut.u_counter.r_uptime = 64'h0000_0001_FFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.u_counter.r_uptime;
    bus_write(4'd6, 32'h0, 4'h1);  // unfreeze; this edge still holds
    bus_read(4'd3, d, v);          // sees 1_FFFF_FFFF, carries afterwards
    tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL snap_lo: got %h expected %h", d, 32'hFFFF_FFFF); end
    bus_read(4'd4, d, v);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL snap_hi: got %h expected %h", d, 32'h1); end
    tests++; if (dut.u_counter.r_uptime[63:32] !== 32'h2) begin fails++; $display("FAIL live_hi: got %h expected %h", dut.u_counter.r_uptime[63:32], 32'h2); end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    logic v;
    repeat (100) @(negedge clk);
    bus_write(4'd6, 32'h1, 4'h1);
    bus_read(4'd3, d, v);   // edge after clear: 0
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL clear_lo0: got %h expected %h", d, 32'h0); end
    bus_read(4'd3, d, v);   // one increment later: 1
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL clear_lo1: got %h expected %h", d, 32'h1); end
    bus_read(4'd5, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL clear_seconds: got %h expected %h", d, 32'h0); end
    bus_read(4'd6, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL clear_ctrl_rb: got %h expected %h", d, 32'h0); end
    bus_read(4'd8, d, v);
    tests++; if (d !== 32'h00AD_00EF) begin fails++; $display("FAIL clear_keeps_scratch: got %h expected %h", d, 32'h00AD_00EF); end
    bus_write(4'd6, 32'h3, 4'h1);  // clear and freeze together
    bus_read(4'd3, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL clrfrz_lo_a: got %h expected %h", d, 32'h0); end
    bus_read(4'd3, d, v);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL clrfrz_lo_b: got %h expected %h", d, 32'h0); end
    bus_read(4'd6, d, v);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL clrfrz_ctrl: got %h expected %h", d, 32'h2); end
    bus_write(4'd6, 32'h0, 4'h1);
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] d;
    logic v;
    address = 4'd9;
    writedata = 32'hCAFE_F00D;
    byteenable = 4'hF;
    read = 1'b1;
    write = 1'b1;
    @(negedge clk);
    read = 1'b0;
    write = 1'b0;
    d = readdata;
    $display("[TB] rdwr  addr=9 data=%h", d);
    tests++; if (d !== 32'h1234_5678) begin fails++; $display("FAIL rw_old: got %h expected %h", d, 32'h1234_5678); end
    bus_read(4'd9, d, v);
    tests++; if (d !== 32'hCAFE_F00D) begin fails++; $display("FAIL rw_new: got %h expected %h", d, 32'hCAFE_F00D); end
  endtask

  task automatic test_async_reset();
    repeat (5) @(negedge clk);
    address = 4'd3;
    read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    tests++; if (readdatavalid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %b expected %b", readdatavalid, 1'b1); end
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] async reset valid=%b data=%h", readdatavalid, readdata);
    tests++; if (readdatavalid !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b expected %b", readdatavalid, 1'b0); end
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL areset_data: got %h expected %h", readdata, 32'h0); end
    tests++; if (dut.u_counter.r_uptime !== 64'h0) begin fails++; $display("FAIL areset_uptime: got %h expected %h", dut.u_counter.r_uptime, 64'h0); end
    tests++; if (dut.u_counter.r_seconds !== 32'h0) begin fails++; $display("FAIL areset_seconds: got %h expected %h", dut.u_counter.r_seconds, 32'h0); end
    tests++; if (dut.r_snap_hi !== 32'h0) begin fails++; $display("FAIL areset_snap: got %h expected %h", dut.r_snap_hi, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_seconds();
    test_ident();
    test_scratch();
    test_snapshot();
    test_clear();
    test_rw_same_cycle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
